window_buffer: RTL and testbench
================================

Name: window_buffer

Overview:
- Parametrised successor to the fixed 4x4-tile / 3x3-window image buffer.
- Stores one square tile of TILE x TILE pixels and presents a K x K convolution window to the convolution engine.
- Steps the window in raster order by STRIDE each time the engine reports calc_done.
- Adds explicit window-valid, window-position, tile-done and busy signalling, which the fixed version lacks.

Parameters:
PIX_W, 4, bits per pixel
TILE, 4, tile edge length in pixels
K, 3, window edge length in pixels
STRIDE, 1, window step in pixels (both axes)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
load_enable  input  1  capture tile_pixels this cycle and restart the window sequence
tile_pixels  input  [TILE-1:0][TILE-1:0][PIX_W-1:0]  incoming tile, indexed [row][col]
calc_done  input  1  engine finished the current window; advance
conv_pixels  output  [K-1:0][K-1:0][PIX_W-1:0]  current window, indexed [row][col]
win_valid  output  1  conv_pixels holds a window not yet consumed
win_row  output  $clog2(N) (min 1)  current window row index
win_col  output  $clog2(N) (min 1)  current window column index
tile_done  output  1  one-cycle pulse after the last window is consumed
busy  output  1  high in ACTIVE

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Window count: N = (TILE-K)/STRIDE + 1 positions per axis; N*N windows per tile.
- Elaboration checks: K <= TILE and (TILE-K) % STRIDE == 0, otherwise elaboration fails via $error.
- Reset values: state EMPTY; tile storage all 0; win_row = win_col = 0; win_valid = 0; tile_done = 0; busy = 0; conv_pixels = 0.
- State EMPTY: no tile held. conv_pixels forced to 0. calc_done ignored.
- State ACTIVE: win_valid = 1, busy = 1.
- conv_pixels[r][c] = tile[win_row*STRIDE + r][win_col*STRIDE + c].
- conv_pixels is selected combinationally from the registered tile and registered position, so it is valid in the same cycle win_valid is high.
- State DONE: win_valid = 0, busy = 0. conv_pixels holds the last window. calc_done ignored.
- Load: load_enable = 1 in any state:
  - the tile is captured at the clock edge;
  - win_row and win_col are set to 0;
  - the next state is ACTIVE;
  - the first window is valid 1 cycle after load_enable is sampled.
- Advance: calc_done = 1 in ACTIVE, no load:
  - if win_col < N-1: win_col increments;
  - else: win_col goes to 0 and win_row increments;
  - the new window is visible the next cycle.
- Last window: calc_done at (N-1, N-1):
  - next state is DONE;
  - tile_done = 1 for exactly one cycle;
  - the position registers hold (N-1, N-1).
- Simultaneous load_enable and calc_done: load wins. The new tile starts at (0,0). No tile_done pulse, even if the old window was the last.
- Reload mid-sequence: allowed. Remaining windows of the old tile are discarded.
- calc_done held high: advances once per cycle, one window per clock.
- N = 1 (K == TILE): a single window. The first calc_done goes directly to DONE with a tile_done pulse.
- Reset asserted mid-operation: all registers return to reset values immediately, asynchronously.
- All outputs except conv_pixels are registered or decoded directly from state.

Decomposition:
- Package window_pkg:
  - state enum win_state_t {EMPTY, ACTIVE, DONE};
  - function num_pos(TILE, K, STRIDE) returning N;
  - function pos_w(N) returning the position width, minimum 1.
- Sub-module window_pos_counter owns the row/column raster counter and wrap logic:
  - inputs: clk, n_rst, clear, advance;
  - outputs: row, col, last.
- The top level holds tile storage, the state machine and the window mux.

Test Plan:
1. Defaults, reset then load tile with pixel value (4*r + c) & 0xF:
   - next cycle win_valid = 1 and (win_row, win_col) = (0,0);
   - conv_pixels row 0 = {0,1,2}, row 2 = {8,9,10}.
2. Defaults, four calc_done pulses one cycle apart:
   - positions step (0,1), (1,0), (1,1);
   - window at (1,1) row 0 = {5,6,7};
   - on the 4th pulse tile_done = 1 for one cycle, then win_valid = 0 and busy = 0.
3. calc_done in EMPTY and in DONE: no change to position, state or tile_done.
4. load_enable and calc_done together at position (1,0): next cycle position (0,0), new tile shown, tile_done stays 0.
5. TILE=6, K=3, STRIDE=3 (N=2) with the same pixel formula (6*r + c) & 0xF:
   - window at (1,1) has top-left pixel tile[3][3] = 21 & 0xF = 5;
   - exactly 4 windows precede tile_done.
6. Assert n_rst mid-sequence at (1,0): outputs go to 0 asynchronously. After release, the state is EMPTY and conv_pixels = 0 until the next load.

Source files
------------

// File: rtl/window_pkg.sv
// Shared types and elaboration helpers for the window buffer.
//   win_state_t : EMPTY (no tile), ACTIVE (windows pending), DONE (tile consumed)
//   num_pos     : window positions per axis for a TILE/K/STRIDE combination
//   pos_w       : bit width of a position index, never less than 1
package window_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } win_state_t;

  function automatic int num_pos(input int tile, input int k, input int stride);
    return (tile - k) / stride + 1;
  endfunction

  function automatic int pos_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_pos_counter.sv
// Raster-order window position counter.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   clear      : return to (0,0); takes priority over advance
//   advance    : step to the next position; ignored at the final position
//   row, col   : current window position
//   last       : position is (N-1, N-1)
module window_pos_counter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic          advance,
  output logic [PW-1:0] row,
  output logic [PW-1:0] col,
  output logic          last
);

  localparam logic [PW-1:0] MAX_POS = PW'(N - 1);

  assign last = (row == MAX_POS) && (col == MAX_POS);

  // The final position is held so the last window stays visible in DONE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance && !last) begin
      if (col == MAX_POS) begin
        col <= '0;
        row <= row + PW'(1);
      end else begin
        col <= col + PW'(1);
      end
    end
  end

endmodule

// File: rtl/window_buffer.sv
// Tile buffer presenting a K x K convolution window that steps through a
// TILE x TILE tile in raster order by STRIDE on every calc_done.
// Ports:
//   clk, n_rst    : clock, asynchronous active-low reset
//   load_enable   : capture tile_pixels and restart at window (0,0)
//   tile_pixels   : incoming tile, [row][col]
//   calc_done     : engine consumed the current window
//   conv_pixels   : current window, [row][col]; zero while no tile is held
//   win_valid     : a window is pending consumption
//   win_row/col   : current window position
//   tile_done     : one-cycle pulse after the last window is consumed
//   busy          : windows remain for the current tile
module window_buffer import window_pkg::*; #(
  parameter  int PIX_W  = 4,
  parameter  int TILE   = 4,
  parameter  int K      = 3,
  parameter  int STRIDE = 1,
  localparam int N      = num_pos(TILE, K, STRIDE),
  localparam int PW     = pos_w(N)
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic                                 load_enable,
  input  logic [TILE-1:0][TILE-1:0][PIX_W-1:0] tile_pixels,
  input  logic                                 calc_done,
  output logic [K-1:0][K-1:0][PIX_W-1:0]       conv_pixels,
  output logic                                 win_valid,
  output logic [PW-1:0]                        win_row,
  output logic [PW-1:0]                        win_col,
  output logic                                 tile_done,
  output logic                                 busy
);

  if (K > TILE || ((TILE - K) % STRIDE) != 0) begin : g_param_check
    $error("window_buffer: need K <= TILE and (TILE-K) divisible by STRIDE");
  end

  localparam int TIW = (TILE > 1) ? $clog2(TILE) : 1;

  win_state_t state, state_next;
  logic [TILE-1:0][TILE-1:0][PIX_W-1:0] tile;
  logic advance;
  logic last;

  // A load always wins over calc_done, so a simultaneous pair never pulses tile_done.
  assign advance = (state == ACTIVE) && calc_done && !load_enable;

  window_pos_counter #(.N(N), .PW(PW)) u_pos (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (load_enable),
    .advance (advance),
    .row     (win_row),
    .col     (win_col),
    .last    (last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (load_enable) begin
      state_next = ACTIVE;
    end else if (advance && last) begin
      state_next = DONE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tile      <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= advance && last;
      if (load_enable) begin
        tile <= tile_pixels;
      end
    end
  end

  assign win_valid = (state == ACTIVE);
  assign busy      = (state == ACTIVE);

  // Window select: combinational from registered tile and position so the
  // window is present in the same cycle as win_valid.
  always_comb begin
    conv_pixels = '0;
    if (state != EMPTY) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          conv_pixels[r][c] = tile[TIW'(int'(win_row) * STRIDE + r)]
                                  [TIW'(int'(win_col) * STRIDE + c)];
        end
      end
    end
  end

endmodule

// File: tb/tb_window_buffer.sv
module tb_window_buffer;

  localparam int S  = 1;
  localparam int NN = 2;   // (4-3)/1+1

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  // Default instance: TILE=4, K=3, STRIDE=1
  logic                    load_enable, calc_done;
  logic [3:0][3:0][3:0]    tile_pixels;
  logic [2:0][2:0][3:0]    conv_pixels;
  logic                    win_valid, tile_done, busy;
  logic [0:0]              win_row, win_col;

  window_buffer dut (
    .clk(clk), .n_rst(n_rst), .load_enable(load_enable), .tile_pixels(tile_pixels),
    .calc_done(calc_done), .conv_pixels(conv_pixels), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .tile_done(tile_done), .busy(busy)
  );

  // Strided instance: TILE=6, K=3, STRIDE=3 (N=2)
  logic                    ld6, cd6;
  logic [5:0][5:0][3:0]    t6;
  logic [2:0][2:0][3:0]    conv6;
  logic                    vld6, done6, busy6;
  logic [0:0]              row6, col6;

  window_buffer #(.PIX_W(4), .TILE(6), .K(3), .STRIDE(3)) dut6 (
    .clk(clk), .n_rst(n_rst), .load_enable(ld6), .tile_pixels(t6),
    .calc_done(cd6), .conv_pixels(conv6), .win_valid(vld6),
    .win_row(row6), .win_col(col6), .tile_done(done6), .busy(busy6)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][3:0][3:0] pat4(input int xr);
    logic [3:0][3:0][3:0] p;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        p[r][c] = 4'(((4 * r + c) ^ xr) & 15);
    return p;
  endfunction

  function automatic logic [5:0][5:0][3:0] pat6();
    logic [5:0][5:0][3:0] p;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        p[r][c] = 4'((6 * r + c) & 15);
    return p;
  endfunction

  // Behavioural model of the default instance: windows are numbered
  // 0..N*N-1 in raster order; state 0=no tile, 1=windows pending, 2=consumed.
  int m_state;
  int m_idx;
  bit m_pulse;
  int m_tile [4][4];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_state <= 0;
      m_idx   <= 0;
      m_pulse <= 1'b0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          m_tile[r][c] <= 0;
    end else begin
      m_pulse <= 1'b0;
      if (load_enable) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            m_tile[r][c] <= int'(tile_pixels[r][c]);
        m_idx   <= 0;
        m_state <= 1;
      end else if (m_state == 1 && calc_done) begin
        if (m_idx == NN * NN - 1) begin
          m_state <= 2;
          m_pulse <= 1'b1;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int er, ec;
    logic [2:0][2:0][3:0] exp_px;
    if (chk_en) begin
      er = m_idx / NN;
      ec = m_idx % NN;
      exp_px = '0;
      if (m_state != 0)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_px[r][c] = 4'(m_tile[er * S + r][ec * S + c]);
      check("m_win_valid", win_valid, m_state == 1);
      check("m_busy",      busy,      m_state == 1);
      check("m_tile_done", tile_done, m_pulse);
      check("m_win_row",   win_row,   er);
      check("m_win_col",   win_col,   ec);
      check("m_conv",      conv_pixels, exp_px);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  nwin;
  bit  got_done;

  initial begin
    n_rst = 1'b0;
    load_enable = 1'b0; calc_done = 1'b0; tile_pixels = '0;
    ld6 = 1'b0; cd6 = 1'b0; t6 = '0;
    #12;
    check("rst_valid", win_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", tile_done, 0);
    check("rst_conv", conv_pixels, 0);
    check("rst_pos", {win_row, win_col}, 0);
    n_rst = 1'b1;
    chk_en = 1'b1;

    // Load tile (4r+c)
    tick();
    load_enable = 1'b1; tile_pixels = pat4(0);
    tick();
    load_enable = 1'b0;
    check("t1_valid", win_valid, 1);
    check("t1_pos", {win_row, win_col}, 2'b00);
    check("t1_r0", {conv_pixels[0][0], conv_pixels[0][1], conv_pixels[0][2]}, 12'h012);
    check("t1_r2", {conv_pixels[2][0], conv_pixels[2][1], conv_pixels[2][2]}, 12'h89A);

    // Four calc_done pulses, one idle cycle between
    calc_done = 1'b1; tick(); calc_done = 1'b0;
    check("t2_pos1", {win_row, win_col}, 2'b01);
    tick();
    calc_done = 1'b1; tick(); calc_done = 1'b0;
    check("t2_pos2", {win_row, win_col}, 2'b10);
    tick();
    calc_done = 1'b1; tick(); calc_done = 1'b0;
    check("t2_pos3", {win_row, win_col}, 2'b11);
    check("t2_r0", {conv_pixels[0][0], conv_pixels[0][1], conv_pixels[0][2]}, 12'h567);
    check("t2_nodone", tile_done, 0);
    tick();
    calc_done = 1'b1; tick(); calc_done = 1'b0;
    check("t2_done", tile_done, 1);
    check("t2_valid0", win_valid, 0);
    check("t2_busy0", busy, 0);
    check("t2_hold", conv_pixels[0][0], 4'h5);
    tick();
    check("t2_done1cyc", tile_done, 0);

    // calc_done in DONE is ignored
    calc_done = 1'b1; tick(); tick(); calc_done = 1'b0;
    check("t3_done_pos", {win_row, win_col}, 2'b11);
    check("t3_done_pulse", tile_done, 0);
    check("t3_done_busy", busy, 0);

    // Load B, advance to (1,0) with calc_done held, then load+calc_done
    load_enable = 1'b1; tile_pixels = pat4(15);
    tick();
    load_enable = 1'b0;
    check("t4_b00", conv_pixels[0][0], 4'hF);
    calc_done = 1'b1; tick(); tick();
    check("t4_pos10", {win_row, win_col}, 2'b10);
    load_enable = 1'b1; tile_pixels = pat4(0);
    tick();
    load_enable = 1'b0; calc_done = 1'b0;
    check("t4_pos00", {win_row, win_col}, 2'b00);
    check("t4_newtile", conv_pixels[1][2], 4'h6);
    check("t4_nodone", tile_done, 0);
    // Same collision at the last window
    calc_done = 1'b1; tick(); tick(); tick();
    check("t4_pos11", {win_row, win_col}, 2'b11);
    load_enable = 1'b1; tile_pixels = pat4(15);
    tick();
    load_enable = 1'b0; calc_done = 1'b0;
    check("t4_last_nodone", tile_done, 0);
    check("t4_last_valid", win_valid, 1);
    check("t4_last_pos", {win_row, win_col}, 2'b00);
    check("t4_last_px", conv_pixels[0][0], 4'hF);

    // Asynchronous reset mid-sequence at (1,0)
    calc_done = 1'b1; tick(); tick(); calc_done = 1'b0;
    check("t6_pos10", {win_row, win_col}, 2'b10);
    #2 n_rst = 1'b0;
    #1;
    check("t6_valid", win_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_pos", {win_row, win_col}, 0);
    check("t6_conv", conv_pixels, 0);
    #3 n_rst = 1'b1;
    tick(); tick();
    check("t6_empty_valid", win_valid, 0);
    check("t6_empty_conv", conv_pixels, 0);
    // calc_done in EMPTY is ignored
    calc_done = 1'b1; tick(); tick(); calc_done = 1'b0;
    check("t3_empty_pos", {win_row, win_col}, 0);
    check("t3_empty_done", tile_done, 0);
    check("t3_empty_valid", win_valid, 0);

    // Strided instance: count windows before tile_done
    ld6 = 1'b1; t6 = pat6();
    tick();
    ld6 = 1'b0;
    check("t5_valid", vld6, 1);
    check("t5_first", conv6[0][0], 4'h0);
    nwin = 0; got_done = 1'b0;
    cd6 = 1'b1;
    for (int i = 0; i < 10 && !got_done; i++) begin
      if (vld6) begin
        nwin++;
        if (row6 == 1'b1 && col6 == 1'b1) begin
          check("t5_tl33", conv6[0][0], 4'h5);
          check("t5_br55", conv6[2][2], 4'h3);
        end
      end
      tick();
      if (done6) got_done = 1'b1;
    end
    cd6 = 1'b0;
    check("t5_nwin", nwin, 4);
    check("t5_done_seen", got_done, 1);
    tick();
    check("t5_busy0", busy6, 0);

    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
